// File: rtl/reg_file_pkg.sv
// Shared definitions for the configuration register file: default widths,
// named cfg entry addresses, reset contents and command decode type.
package reg_file_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [3:0] ALU_OP_ADDR    = 4'd0;
  localparam logic [3:0] UART_CFG_ADDR  = 4'd2;
  localparam logic [3:0] DIV_RATIO_ADDR = 4'd3;

  // Entry i lives in slice i: entry 3 = 8'h08, entry 2 = 8'h21.
  localparam logic [31:0] RST_VALS_DEF = {8'h08, 8'h21, 8'h00, 8'h00};

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_WRITE,
    CMD_READ,
    CMD_CLASH
  } cmd_t;

endpackage

// File: rtl/rf_rd_pipe.sv
// RD_LAT-deep (1 or 2) read return delay line carrying data, valid and flag
// bits; synchronous flush. Output data holds its last value when not valid.
module rf_rd_pipe
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FLAG_W = 1,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [FLAG_W-1:0] out_flags
);

  typedef struct packed {
    logic              valid;
    logic [FLAG_W-1:0] flags;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t s0;
  stage_t s_out;

  always_ff @(posedge clk) begin
    if (flush) begin
      s0 <= '0;
    end else begin
      s0.valid <= in_valid;
      s0.flags <= in_flags;
      if (in_valid) s0.data <= in_data;
    end
  end

  generate
    if (RD_LAT > 1) begin : g_two
      stage_t s1;
      always_ff @(posedge clk) begin
        if (flush) begin
          s1 <= '0;
        end else begin
          s1.valid <= s0.valid;
          s1.flags <= s0.flags;
          if (s0.valid) s1.data <= s0.data;
        end
      end
      assign s_out = s1;
    end else begin : g_one
      assign s_out = s0;
    end
  endgenerate

  assign out_valid = s_out.valid;
  assign out_data  = s_out.data;
  assign out_flags = s_out.flags;

endmodule

// File: rtl/reg_file_cfg.sv
// Parametrised configuration register file with read-only protection, 1/2
// cycle read latency and command-error pulses. Optional: REG_FILE_CFG_PARITY_EN.
module reg_file_cfg
  import reg_file_pkg::*;
#(
  parameter int unsigned                   ADDR_W   = ADDR_W_DEF,
  parameter int unsigned                   DATA_W   = DATA_W_DEF,
  parameter int unsigned                   DEPTH    = 16,
  parameter int unsigned                   NUM_CFG  = 4,
  parameter int unsigned                   RD_LAT   = 1,
  parameter logic [DEPTH-1:0]              RO_MASK  = '0,
  parameter logic [NUM_CFG*DATA_W-1:0]     RST_VALS = RST_VALS_DEF
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      RdEn,
  input  logic                      WrEn,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         WrData,
  output logic [DATA_W-1:0]         RdData,
  output logic                      Rd_dataValid,
  output logic                      Cmd_err,
`ifdef REG_FILE_CFG_PARITY_EN
  output logic                      Rd_parErr,
`endif
  output logic [NUM_CFG*DATA_W-1:0] cfg_regs
);

`ifdef REG_FILE_CFG_PARITY_EN
  localparam int unsigned PAR_W  = 1;
  localparam int unsigned FLAG_W = 2;
`else
  localparam int unsigned PAR_W  = 0;
  localparam int unsigned FLAG_W = 1;
`endif
  localparam int unsigned MEM_W = DATA_W + PAR_W;
  localparam int unsigned SPAN  = 1 << ADDR_W;
  // Mask widened to the full address span so any address indexes it safely.
  localparam logic [SPAN-1:0]   RO_FULL = SPAN'(RO_MASK);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef REG_FILE_CFG_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0] mem      [DEPTH];
  logic [MEM_W-1:0] rst_word [DEPTH];

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_rst
      if (g < NUM_CFG) begin : g_cfg
        assign rst_word[g] = encode(RST_VALS[g*DATA_W +: DATA_W]);
      end else begin : g_zero
        assign rst_word[g] = '0;
      end
    end
    for (genvar g = 0; g < NUM_CFG; g++) begin : g_out
      assign cfg_regs[g*DATA_W +: DATA_W] = mem[g][DATA_W-1:0];
    end
  endgenerate

  cmd_t             cmd;
  logic             in_range;
  logic             ro_hit;
  logic             wr_ok;
  logic             err_now;
  logic             rd_acc;
  logic [MEM_W-1:0] rd_word;
  logic [FLAG_W-1:0] flags_in;
  logic [FLAG_W-1:0] flags_out;
  logic             cmd_err_q;

  always_comb begin
    case ({WrEn, RdEn})
      2'b10:   cmd = CMD_WRITE;
      2'b01:   cmd = CMD_READ;
      2'b11:   cmd = CMD_CLASH;
      default: cmd = CMD_IDLE;
    endcase
    in_range = {1'b0, address} < DEPTH_L;
    ro_hit   = RO_FULL[address];
    wr_ok    = (cmd == CMD_WRITE) && in_range && !ro_hit;
    err_now  = (cmd == CMD_CLASH) || ((cmd == CMD_WRITE) && !wr_ok);
    rd_acc   = (cmd == CMD_READ);
    rd_word  = in_range ? mem[address] : '0;
`ifdef REG_FILE_CFG_PARITY_EN
    // Stored word including parity must XOR to zero; out-of-range reads are all-zero.
    flags_in = {rd_acc && (^rd_word), rd_acc && !in_range};
`else
    flags_in = rd_acc && !in_range;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem       <= rst_word;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= err_now;
      if (wr_ok) mem[address] <= encode(WrData);
    end
  end

  rf_rd_pipe #(
    .DATA_W (DATA_W),
    .FLAG_W (FLAG_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (Clk),
    .flush     (Rst),
    .in_valid  (rd_acc),
    .in_data   (rd_word[DATA_W-1:0]),
    .in_flags  (flags_in),
    .out_valid (Rd_dataValid),
    .out_data  (RdData),
    .out_flags (flags_out)
  );

  // Immediate command errors and out-of-range read errors share one pulse output.
  assign Cmd_err = cmd_err_q | flags_out[0];
`ifdef REG_FILE_CFG_PARITY_EN
  assign Rd_parErr = flags_out[1];
`endif

endmodule

// File: tb/tb_reg_file_cfg.sv
// Bench for reg_file_cfg: two instances (RD_LAT=1/DEPTH=16, RD_LAT=2/DEPTH=12),
// directed test-plan steps followed by random commands against a reference model.
module tb_reg_file_cfg;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [7:0]  wdata;

  logic [7:0]  rd_a, rd_b;
  logic        v_a, v_b;
  logic        e_a, e_b;
  logic [31:0] cfg_a, cfg_b;
`ifdef REG_FILE_CFG_PARITY_EN
  logic        pe_a, pe_b;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  reg_file_cfg #(
    .RD_LAT  (1),
    .RO_MASK (16'h0001)
  ) u_a (
    .Clk          (clk),
    .Rst          (rst),
    .RdEn         (rd_en),
    .WrEn         (wr_en),
    .address      (addr),
    .WrData       (wdata),
    .RdData       (rd_a),
    .Rd_dataValid (v_a),
    .Cmd_err      (e_a),
`ifdef REG_FILE_CFG_PARITY_EN
    .Rd_parErr    (pe_a),
`endif
    .cfg_regs     (cfg_a)
  );

  reg_file_cfg #(
    .DEPTH   (12),
    .RD_LAT  (2),
    .RO_MASK (12'h001)
  ) u_b (
    .Clk          (clk),
    .Rst          (rst),
    .RdEn         (rd_en),
    .WrEn         (wr_en),
    .address      (addr),
    .WrData       (wdata),
    .RdData       (rd_b),
    .Rd_dataValid (v_b),
    .Cmd_err      (e_b),
`ifdef REG_FILE_CFG_PARITY_EN
    .Rd_parErr    (pe_b),
`endif
    .cfg_regs     (cfg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents per instance plus a timeline of scheduled responses.
  int          depth_m [2] = '{16, 12};
  int          lat_m   [2] = '{1, 2};
  logic [15:0] ro_m = 16'h0001;
  logic [7:0]  mm      [2][16];
  logic        sl_v    [2][4];
  logic        sl_e    [2][4];
  logic [7:0]  sl_d    [2][4];
  logic        exp_v   [2];
  logic        exp_e   [2];
  logic [7:0]  last_d  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_edge(input int k);
    int now;
    int s;
    logic in_r;
    now = cyc % 4;
    if (rst) begin
      for (int i = 0; i < 16; i++) mm[k][i] = 8'h00;
      mm[k][2] = 8'h21;
      mm[k][3] = 8'h08;
      for (int i = 0; i < 4; i++) begin
        sl_v[k][i] = 1'b0;
        sl_e[k][i] = 1'b0;
        sl_d[k][i] = 8'h00;
      end
      exp_v[k]  = 1'b0;
      exp_e[k]  = 1'b0;
      last_d[k] = 8'h00;
    end else begin
      in_r = int'(addr) < depth_m[k];
      if (wr_en && rd_en) begin
        sl_e[k][now] = 1'b1;
      end else if (wr_en) begin
        if (in_r && !ro_m[addr]) mm[k][addr] = wdata;
        else sl_e[k][now] = 1'b1;
      end else if (rd_en) begin
        s = (cyc + lat_m[k] - 1) % 4;
        sl_v[k][s] = 1'b1;
        sl_d[k][s] = in_r ? mm[k][addr] : 8'h00;
        if (!in_r) sl_e[k][s] = 1'b1;
      end
      exp_v[k] = sl_v[k][now];
      exp_e[k] = sl_e[k][now];
      if (exp_v[k]) last_d[k] = sl_d[k][now];
      sl_v[k][now] = 1'b0;
      sl_e[k][now] = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] a,
                      input logic [7:0] d, input logic rs);
    rst   = rs;
    rd_en = r;
    wr_en = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("valid_a", 32'(v_a),  32'(exp_v[0]));
    chk("data_a",  32'(rd_a), 32'(last_d[0]));
    chk("err_a",   32'(e_a),  32'(exp_e[0]));
    chk("cfg_a",   cfg_a, {mm[0][3], mm[0][2], mm[0][1], mm[0][0]});
    chk("valid_b", 32'(v_b),  32'(exp_v[1]));
    chk("data_b",  32'(rd_b), 32'(last_d[1]));
    chk("err_b",   32'(e_b),  32'(exp_e[1]));
    chk("cfg_b",   cfg_b, {mm[1][3], mm[1][2], mm[1][1], mm[1][0]});
`ifdef REG_FILE_CFG_PARITY_EN
    chk("parerr_a", 32'(pe_a), 32'd0);
    chk("parerr_b", 32'(pe_b), 32'd0);
`endif
    cyc++;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;

    // Reset dominates a simultaneous write and read.
    step(1'b0, 1'b1, 4'd2, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    chk("cfg_reset_a", cfg_a, 32'h0821_0000);
    chk("cfg_reset_b", cfg_b, 32'h0821_0000);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    step(1'b0, 1'b1, 4'd7, 8'hA5, 1'b0);
    step(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("readback_b", 32'(rd_b), 32'h0000_00A5);

    step(1'b0, 1'b1, 4'd0, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("ro_slice0_a", 32'(cfg_a[7:0]), 32'h0);

    step(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0);
    step(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    step(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    step(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    step(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    step(1'b0, 1'b1, 4'd7, 8'hA5, 1'b0);
    step(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    step(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("post_reset_data_b", 32'(rd_b), 32'h0);

    step(1'b1, 1'b0, 4'd13, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      step(sel < 40, (sel >= 40 && sel < 75) || (sel >= 95),
           4'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 59) == 0));
    end
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_cfg.md
Name: reg_file_cfg

Overview:
- Parametrised configuration register file; successor to the 16x8 system register file.
- Sits between the system controller (read/write command port) and the datapath blocks (UART, divider, ALU), which consume the first NUM_CFG entries as always-visible configuration outputs.
- Adds over the previous generation:
  - generic depth/width
  - read-only address protection
  - configurable read latency
  - explicit command-error reporting
  - single-cycle read-valid pulses

Parameters:
- ADDR_W, 4, address width in bits.
- DATA_W, 8, data width in bits.
- DEPTH, 16, number of entries; must satisfy NUM_CFG <= DEPTH <= 2**ADDR_W.
- NUM_CFG, 4, number of low entries exported on cfg_regs.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RO_MASK, 0, DEPTH-bit mask; bit i set means entry i is read-only.
- RST_VALS, {8'h08, 8'h21, 8'h00, 8'h00}, NUM_CFG*DATA_W packed reset values; entry i is in slice i.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- RdEn  in  1  read request, sampled each cycle.
- WrEn  in  1  write request, sampled each cycle.
- address  in  ADDR_W  entry index.
- WrData  in  DATA_W  write data.
- RdData  out  DATA_W  read data; registered.
- Rd_dataValid  out  1  one-cycle pulse qualifying RdData.
- Cmd_err  out  1  one-cycle pulse on an illegal command.
- cfg_regs  out  NUM_CFG*DATA_W  entries 0..NUM_CFG-1, flattened, entry i at slice i; driven combinationally from storage.

Behaviour:
- Reset (Rst high at a rising edge):
  - Entries 0..NUM_CFG-1 load their RST_VALS slice; all other entries load 0.
  - RdData=0, Rd_dataValid=0, Cmd_err=0; read pipeline flushed.
  - Reset dominates every command in the same cycle. A read issued before reset whose result has not yet emerged never produces a valid.
- Command decode, per cycle:
  - WrEn=1, RdEn=0, address<DEPTH, RO_MASK[address]=0: entry written at this edge.
  - WrEn=1, RdEn=0, read-only entry or address>=DEPTH: write dropped; Cmd_err=1 next cycle.
  - RdEn=1, WrEn=0, address<DEPTH: read accepted.
  - RdEn=1, WrEn=0, address>=DEPTH: read accepted, returns 0; Cmd_err pulses at the same cycle as Rd_dataValid.
  - RdEn=1 and WrEn=1: no access; Cmd_err=1 next cycle; no valid.
  - Neither asserted: idle.
- Read latency:
  - RD_LAT=1: RdData and Rd_dataValid appear on the edge that samples RdEn.
  - RD_LAT=2: one further register stage.
  - Back-to-back reads every cycle are supported; one valid per accepted read, in order.
- Valid and hold rules:
  - Rd_dataValid is high only in the cycle(s) corresponding to accepted reads.
  - RdData holds its last value when not valid.
- Write-then-read: a write at edge N is visible to a read sampled at edge N+1 or later. cfg_regs reflects the new value after edge N.
- Entries beyond DEPTH are not implemented.

Optional Feature:
- Macro: REG_FILE_CFG_PARITY_EN.
- When defined:
  - Each entry stores one extra even-parity bit, computed on write and on reset load.
  - Reads recompute parity. A mismatch pulses an additional output Rd_parErr together with Rd_dataValid, and the data is still returned.
- When undefined:
  - No parity storage and no Rd_parErr port.
  - All other behaviour is identical.

Decomposition:
- Shared package reg_file_pkg holds:
  - default ADDR_W/DATA_W;
  - named address constants for the cfg entries (ALU_OP_ADDR, UART_CFG_ADDR, DIV_RATIO_ADDR);
  - default RST_VALS constant.
- One natural sub-module, rf_rd_pipe: parametrised RD_LAT-deep delay line carrying data, valid, error and (optional) parity-error bits with synchronous flush.

Test Plan:
- Reset check: Rst pulse, then read every address 0..15 -> entry 2 returns 8'h21, entry 3 returns 8'h08, all others 8'h00; exactly one valid per read; cfg_regs = {08,21,00,00}.
- Write/read-back: write 8'hA5 to address 7, read address 7 in the next cycle -> RdData=8'hA5 after RD_LAT cycles with a single valid pulse.
- Read-only protection (RO_MASK=16'h0001): write 8'hFF to address 0 -> Cmd_err pulse; cfg_regs slice 0 stays 8'h00.
- Collision (RdEn=WrEn=1, address 5, WrData 8'h3C): Cmd_err pulse, no valid, entry 5 unchanged.
- Throughput (RD_LAT=2): consecutive reads of addresses 2,3,7 -> valids on three consecutive cycles carrying 21,08,A5; Rst asserted during the second read -> no further valids, RdData=0.
- Out of range (DEPTH=12): read address 13 -> RdData=0, valid and Cmd_err together. With REG_FILE_CFG_PARITY_EN defined, forcing a stored parity bit flip -> Rd_parErr pulses with valid.
